ibex_mem_arbiter: RTL and testbench
===================================

# ibex_mem_arbiter

Two-to-one arbiter sharing a single memory port between the ibex core's instruction and data interfaces, placed between the core (or tracing wrapper) and a single-ported memory or bus bridge. Requests are forwarded combinationally under a hold-until-grant lock. Responses are returned in order to the originating interface using a source-ID FIFO.

## Interface
Parameters:
- MaxOutstanding, 2: maximum granted-but-unanswered memory transactions; legal range 1..8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset
- instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1  instruction-side handshake
- instr_addr_i  in  32  instruction address
- instr_rdata_o  out  32  instruction read data
- instr_err_o  out  1  instruction bus error
- data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1  data-side handshake
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  data write data
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data bus error
- mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1  shared-port handshake
- mem_we_o  out  1  shared-port write enable
- mem_be_o  out  4  shared-port byte enables
- mem_addr_o  out  32  shared-port address
- mem_wdata_o  out  32  shared-port write data
- mem_rdata_i  in  32  shared-port read data
- mem_err_i  in  1  shared-port bus error

## Operation
- Protocol (ibex obi-style): a host holds req and attributes stable until gnt. Responses arrive in grant order, each exactly one rvalid.
- Selection `sel`:
  - When `lock_q` is set, `sel` = `lock_src_q`.
  - Otherwise, with one requester, `sel` is that requester.
  - Otherwise, with both requesting, `sel` follows the priority rule (see Configuration).
- `mem_req_o` = (selected req) && !fifo_full.
- mem attributes = selected host's attributes. Instruction transactions drive we=0, be=4'hF, wdata=0.
- Grant: `<sel>_gnt_o` = mem_gnt_i && mem_req_o. The non-selected gnt is 0.
- Lock:
  - On mem_req_o && !mem_gnt_i: set `lock_q` and latch `lock_src_q` = sel.
  - Clear the lock on mem_req_o && mem_gnt_i.
  - While fifo_full, a pending req does not lock, because mem_req_o is 0.
- ID FIFO:
  - Push `sel` on mem_req_o && mem_gnt_i.
  - Pop on mem_rvalid_i when the FIFO is non-empty.
  - Depth = MaxOutstanding.
- Response routing:
  - `<head>_rvalid_o` = mem_rvalid_i && !fifo_empty.
  - rdata_o of both hosts = mem_rdata_i.
  - err_o = mem_err_i gated by the same rvalid routing.
- Full: mem_req_o is forced 0 even if a pop occurs in the same cycle. This keeps rvalid→req free of combinational paths.
- Empty: an rvalid with an empty FIFO is dropped (no host rvalid). This is a protocol violation, flagged by a simulation assertion.
- Simultaneous push and pop at non-full: occupancy unchanged, head advances.

## Timing
- Request path: 0-cycle combinational, req→mem_req_o and mem_gnt_i→host gnt.
- Response path: 0-cycle combinational, mem_rvalid_i→host rvalid.
- State updates on clk_i rising edge.
- Reset values:
  - lock_q=0, lock_src_q=instr.
  - FIFO empty, count=0.
  - rr pointer = data-preferred.
  - Under reset with host reqs low, every output is 0.
- Reset asserted mid-transaction clears all state immediately (asynchronous). Responses still in flight are not routed after reset.
- Occupancy counter is $clog2(MaxOutstanding+1) bits wide and never wraps. Read/write pointers wrap modulo MaxOutstanding.

## Configuration
- IBEX_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, data over instr, when both request and unlocked.
- IBEX_ARB_ROUND_ROBIN_EN defined:
  - A 1-bit `rr_q` prefers the source not granted last.
  - `rr_q` updates on every mem grant to the opposite of the granted source.
  - Reset value prefers data.
- Lock, FIFO and response behaviour are identical in both builds.

## Structure
- ibex_pkg: add `typedef enum logic {ArbSrcInstr = 1'b0, ArbSrcData = 1'b1} arb_src_e`.
- Sub-module ibex_arb_id_fifo:
  - Parameterised depth, 1-bit arb_src_e entries.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Asynchronous active-low reset.
- Top level holds the sel/lock/priority logic and muxing.

## Test plan
- Single data read: data_req=1, addr=0x100, gnt same cycle, rvalid one cycle later with rdata=0xDEADBEEF → data_gnt_o=1 in cycle 0; data_rvalid_o=1 and data_rdata_o=0xDEADBEEF in cycle 1; instr_rvalid_o=0 throughout.
- Contention: instr and data request together, gnt held 0 for 3 cycles then 1 → mem_addr_o stays the data address all 4 cycles even if instr_addr changes; data granted first, instr granted on the next gnt. In the round-robin build, two back-to-back contended grants alternate data then instr.
- Outstanding limit: MaxOutstanding=2, two instr grants, no rvalid → third req sees mem_req_o=0. One rvalid → instr_rvalid_o=1 and mem_req_o rises on the next cycle, not the same cycle.
- Ordering: grants instr then data, responses rdata 0x1 then 0x2 → instr_rdata_o=0x1 with instr_rvalid_o, then data_rdata_o=0x2 with data_rvalid_o.
- Error and empty: mem_err_i=1 on a data response → data_err_o=1 only. A spurious mem_rvalid_i with an empty FIFO → no host rvalid, and the assertion fires.
- Reset mid-lock: lock set on data, rst_ni low for 1 cycle → lock_q=0 and FIFO empty. After reset, a lone instr_req is forwarded immediately.

Source files
------------

// File: rtl/ibex_mem_arbiter_pkg.sv
// ibex_mem_arbiter_pkg
// Shared types for the instruction/data memory arbiter.
//   arb_src_e : identifies which core interface owns a memory transaction.
//   InstrBe   : byte enables driven for instruction fetches (always full word).
//   arb_other : returns the opposite source (used by round-robin update).
package ibex_mem_arbiter_pkg;

  typedef enum logic {ArbSrcInstr = 1'b0, ArbSrcData = 1'b1} arb_src_e;

  localparam logic [3:0] InstrBe = 4'hF;

  function automatic arb_src_e arb_other(input arb_src_e src);
    if (src == ArbSrcInstr) begin
      return ArbSrcData;
    end else begin
      return ArbSrcInstr;
    end
  endfunction

endpackage

// File: rtl/ibex_arb_id_fifo.sv
// ibex_arb_id_fifo
// Small FIFO of source IDs, one entry per granted-but-unanswered transaction.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, wdata   : enqueue wdata (ignored while full)
//   pop           : dequeue head (ignored while empty)
//   rdata         : current head entry
//   full, empty   : occupancy flags
module ibex_arb_id_fifo
  import ibex_mem_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push,
  input  logic     pop,
  input  arb_src_e wdata,
  output arb_src_e rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  // Storage is rounded up to a power of two so every pointer value indexes a
  // real entry; pointers still wrap at Depth.
  arb_src_e            entries_q [2**PtrW];
  logic [PtrW-1:0]     wptr_q;
  logic [PtrW-1:0]     rptr_q;
  logic [CntW-1:0]     count_q;
  logic                push_ok;
  logic                pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return '0;
    end else begin
      return ptr + PtrW'(1);
    end
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == CntW'(0));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = entries_q[rptr_q];

  // Entry storage and pointer/occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < (2**PtrW); i++) begin
        entries_q[i] <= ArbSrcInstr;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        entries_q[wptr_q] <= wdata;
        wptr_q            <= ptr_inc(wptr_q);
      end else begin
        wptr_q <= wptr_q;
      end
      if (pop_ok) begin
        rptr_q <= ptr_inc(rptr_q);
      end else begin
        rptr_q <= rptr_q;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_mem_arbiter_chk.sv
// ibex_mem_arbiter_chk
// Protocol checker for the arbiter's response side. Flags a memory rvalid
// that arrives while no transaction is outstanding (such a response is
// dropped by the arbiter).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   mem_rvalid_i  : shared-port response valid
//   fifo_empty    : arbiter ID FIFO empty flag
//   violation     : sticky flag, set on the first spurious rvalid
// Parameter AssertEn enables the simulation assertion on the same condition.
module ibex_mem_arbiter_chk #(
  parameter bit AssertEn = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mem_rvalid_i,
  input  logic fifo_empty,
  output logic violation
);

  // Sticky record of a response arriving with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      violation <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty) begin
      violation <= 1'b1;
    end else begin
      violation <= violation;
    end
  end

  spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(AssertEn && mem_rvalid_i && fifo_empty))
    else $error("spurious mem_rvalid_i with no outstanding transaction");

endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
// Shares one memory port between the ibex instruction and data interfaces.
// Requests pass through combinationally; once a request is presented but not
// granted, the arbiter locks onto that source until the grant. Responses are
// routed back in order using a FIFO of source IDs.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   instr_* / data_*      : core-side obi-style interfaces
//   mem_*                 : shared memory-side interface
// Parameter MaxOutstanding (1..8): granted-but-unanswered transaction limit.
// Build option IBEX_ARB_ROUND_ROBIN_EN: when defined, contention is resolved
// round-robin; otherwise data has fixed priority over instruction.
module ibex_mem_arbiter
  import ibex_mem_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  arb_src_e sel;
  arb_src_e prio;
  arb_src_e lock_src_q;
  arb_src_e fifo_head;
  logic     lock_q;
  logic     sel_data;
  logic     sel_req;
  logic     fifo_push;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;
  logic     head_valid;

`ifdef IBEX_ARB_ROUND_ROBIN_EN
  arb_src_e rr_q;

  // Round-robin preference: favour the source that did not win last grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= ArbSrcData;
    end else if (fifo_push) begin
      rr_q <= arb_other(sel);
    end else begin
      rr_q <= rr_q;
    end
  end

  assign prio = rr_q;
`else
  assign prio = ArbSrcData;
`endif

  // Source selection: an ungranted request keeps ownership until granted.
  always_comb begin
    sel = ArbSrcInstr;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      sel = prio;
    end else if (data_req_i) begin
      sel = ArbSrcData;
    end else begin
      sel = ArbSrcInstr;
    end
  end

  assign sel_data  = (sel == ArbSrcData);
  assign sel_req   = sel_data ? data_req_i : instr_req_i;
  // Full is checked on the registered count only, so a same-cycle pop does
  // not reopen the request path (no rvalid-to-req combinational path).
  assign mem_req_o = sel_req && !fifo_full;
  assign fifo_push = mem_req_o && mem_gnt_i;

  assign instr_gnt_o = fifo_push && !sel_data;
  assign data_gnt_o  = fifo_push && sel_data;

  // Attribute mux; attributes are zero when the selected host is idle.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (sel_req) begin
      if (sel_data) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o   = InstrBe;
        mem_addr_o = instr_addr_i;
      end
    end else begin
      mem_we_o = 1'b0;
    end
  end

  // Hold-until-grant lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= ArbSrcInstr;
    end else if (mem_req_o && !mem_gnt_i) begin
      lock_q     <= 1'b1;
      lock_src_q <= sel;
    end else if (fifo_push) begin
      lock_q     <= 1'b0;
      lock_src_q <= lock_src_q;
    end else begin
      lock_q     <= lock_q;
      lock_src_q <= lock_src_q;
    end
  end

  assign fifo_pop = mem_rvalid_i && !fifo_empty;

  ibex_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (sel),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // A response with nothing outstanding is dropped.
  assign head_valid     = mem_rvalid_i && !fifo_empty;
  assign instr_rvalid_o = head_valid && (fifo_head == ArbSrcInstr);
  assign data_rvalid_o  = head_valid && (fifo_head == ArbSrcData);
  assign instr_err_o    = mem_err_i && instr_rvalid_o;
  assign data_err_o     = mem_err_i && data_rvalid_o;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb_ibex_mem_arbiter
// Directed self-checking bench for ibex_mem_arbiter (MaxOutstanding = 2).
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge.
module tb_ibex_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        viol;

  int errors = 0;
  int checks = 0;

  ibex_mem_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_req_i    (instr_req),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_addr_i   (instr_addr),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .mem_err_i      (mem_err)
  );

  ibex_mem_arbiter_chk #(.AssertEn(1'b0)) u_chk (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_rvalid_i (mem_rvalid),
    .fifo_empty   (dut.fifo_empty),
    .violation    (viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic first_data;
    rst_n = 1'b0;
    instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_gnts", {30'h0, instr_gnt, data_gnt}, 32'h0);
    chk("rst_rvalids", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    chk("rst_lock", {31'h0, dut.lock_q}, 32'h0);
    chk("rst_empty", {31'h0, dut.fifo_empty}, 32'h1);
    next_cycle();
    rst_n = 1'b1;

    // Single data read
    data_req = 1'b1; data_addr = 32'h100; data_be = 4'hF; mem_gnt = 1'b1;
    @(negedge clk);
    chk("rd_data_gnt", {31'h0, data_gnt}, 32'h1);
    chk("rd_instr_gnt", {31'h0, instr_gnt}, 32'h0);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_be", {28'h0, mem_be}, 32'hF);
    next_cycle();
    data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_data_rvalid", {31'h0, data_rvalid}, 32'h1);
    chk("rd_data_rdata", data_rdata, 32'hDEADBEEF);
    chk("rd_instr_rvalid", {31'h0, instr_rvalid}, 32'h0);
    next_cycle();
    mem_rvalid = 1'b0;

    // Reset pulse so both builds start contention from the same state
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // Contention with a 3-cycle grant stall
    instr_req = 1'b1; instr_addr = 32'h200;
    data_req = 1'b1; data_addr = 32'h300; data_we = 1'b1; data_wdata = 32'hCAFE0001;
    mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ct_stall_addr", mem_addr, 32'h300);
      chk("ct_stall_gnt", {30'h0, instr_gnt, data_gnt}, 32'h0);
      next_cycle();
      instr_addr = 32'h204;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("ct_data_addr", mem_addr, 32'h300);
    chk("ct_data_gnt", {30'h0, instr_gnt, data_gnt}, 32'h1);
    chk("ct_data_we", {31'h0, mem_we}, 32'h1);
    chk("ct_data_wdata", mem_wdata, 32'hCAFE0001);
    next_cycle();
    data_req = 1'b0; data_we = 1'b0;
    @(negedge clk);
    chk("ct_instr_gnt", {30'h0, instr_gnt, data_gnt}, 32'h2);
    chk("ct_instr_addr", mem_addr, 32'h204);
    chk("ct_instr_we", {31'h0, mem_we}, 32'h0);
    chk("ct_instr_wdata", mem_wdata, 32'h0);
    next_cycle();
    instr_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11;
    @(negedge clk);
    chk("ct_rsp1", {30'h0, instr_rvalid, data_rvalid}, 32'h1);
    next_cycle();
    mem_rdata = 32'h22;
    @(negedge clk);
    chk("ct_rsp2", {30'h0, instr_rvalid, data_rvalid}, 32'h2);
    chk("ct_rsp2_rdata", instr_rdata, 32'h22);
    next_cycle();
    mem_rvalid = 1'b0;

    // Outstanding limit
    instr_req = 1'b1; instr_addr = 32'h400; mem_gnt = 1'b1;
    @(negedge clk);
    chk("ol_gnt1", {31'h0, instr_gnt}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("ol_gnt2", {31'h0, instr_gnt}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("ol_full_req", {31'h0, mem_req}, 32'h0);
    chk("ol_full_gnt", {31'h0, instr_gnt}, 32'h0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h33;
    @(negedge clk);
    chk("ol_pop_rvalid", {31'h0, instr_rvalid}, 32'h1);
    chk("ol_pop_req", {31'h0, mem_req}, 32'h0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("ol_reopen_req", {31'h0, mem_req}, 32'h1);
    chk("ol_reopen_gnt", {31'h0, instr_gnt}, 32'h1);
    next_cycle();
    instr_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    next_cycle();
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("ol_drained", {31'h0, dut.fifo_empty}, 32'h1);
    next_cycle();

    // Ordering and error routing
    instr_req = 1'b1; instr_addr = 32'h500; mem_gnt = 1'b1;
    next_cycle();
    instr_req = 1'b0; data_req = 1'b1; data_addr = 32'h600;
    next_cycle();
    data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1;
    @(negedge clk);
    chk("or_instr_rsp", {30'h0, instr_rvalid, data_rvalid}, 32'h2);
    chk("or_instr_rdata", instr_rdata, 32'h1);
    next_cycle();
    mem_rdata = 32'h2; mem_err = 1'b1;
    @(negedge clk);
    chk("or_data_rsp", {30'h0, instr_rvalid, data_rvalid}, 32'h1);
    chk("or_data_rdata", data_rdata, 32'h2);
    chk("or_errs", {30'h0, instr_err, data_err}, 32'h1);
    next_cycle();
    mem_rvalid = 1'b0; mem_err = 1'b0;

    // Spurious response with nothing outstanding
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("sp_rvalids", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("sp_flag", {31'h0, viol}, 32'h1);
    next_cycle();

    // Back-to-back contended grants (last grant so far was data)
`ifdef IBEX_ARB_ROUND_ROBIN_EN
    first_data = 1'b0;
`else
    first_data = 1'b1;
`endif
    instr_req = 1'b1; instr_addr = 32'h700;
    data_req = 1'b1; data_addr = 32'h800; mem_gnt = 1'b1;
    @(negedge clk);
    chk("bb_first", {30'h0, instr_gnt, data_gnt}, {30'h0, ~first_data, first_data});
    next_cycle();
    @(negedge clk);
    chk("bb_second", {30'h0, instr_gnt, data_gnt}, 32'h1);
    next_cycle();
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
    next_cycle();
    next_cycle();
    mem_rvalid = 1'b0;

    // Reset while locked
    data_req = 1'b1; data_addr = 32'h900;
    next_cycle();
    @(negedge clk);
    chk("rl_locked", {31'h0, dut.lock_q}, 32'h1);
    next_cycle();
    rst_n = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("rl_lock_clr", {31'h0, dut.lock_q}, 32'h0);
    chk("rl_empty", {31'h0, dut.fifo_empty}, 32'h1);
    chk("rl_mem_req", {31'h0, mem_req}, 32'h0);
    next_cycle();
    rst_n = 1'b1; instr_req = 1'b1; instr_addr = 32'hA00;
    @(negedge clk);
    chk("rl_fwd_req", {31'h0, mem_req}, 32'h1);
    chk("rl_fwd_addr", mem_addr, 32'hA00);
    next_cycle();
    instr_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
